lamp_sequence_checker: RTL and testbench



---
 rtl/lamp_sequence_checker.sv | 108 ++++++++++
 tb/tb_lamp_sequence_checker.sv | 103 ++++++++++
 2 files changed

// File: rtl/lamp_sequence_checker.sv
// lamp_sequence_checker: observes the one-hot lamp bus, decodes colour, checks RED->GREEN->YELLOW order.
// Optional macro DWELL_CHECK_EN compiles in the dwell counter and dwell_err (MAX_DWELL) checking.
module lamp_sequence_checker #(
    parameter int MAX_DWELL = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [0:2]       light,
    output logic [1:0]       color,
    output logic             locked,
    output logic             illegal_code,
    output logic             bad_order,
    output logic             dwell_err,
    output logic [CNT_W-1:0] cycle_count,
    output logic             err_sticky
);

    typedef enum logic [1:0] {ACQUIRE = 2'd0, T_RED = 2'd1, T_GREEN = 2'd2, T_YELLOW = 2'd3} state_t;

    if (MAX_DWELL < 1 || MAX_DWELL > 254) begin : g_range
        $error("lamp_sequence_checker: MAX_DWELL must be in 1..254");
    end

    state_t             state, state_nxt;
    logic [0:2]         light_q;
    logic               primed;
    logic               valid, ill, bo, de, locked_nxt;
    logic [1:0]         code, cur, nxt_code;
    logic [CNT_W-1:0]   cnt_nxt;

    // Colour codes equal the tracking state minus one, so the order check is simple arithmetic.
    assign valid    = (light_q == 3'b100) || (light_q == 3'b010) || (light_q == 3'b001);
    assign code     = light_q[0] ? 2'd0 : light_q[1] ? 2'd1 : 2'd2;
    assign cur      = 2'(state) - 2'd1;
    assign nxt_code = (cur == 2'd2) ? 2'd0 : cur + 2'd1;

    // Next-state, lock, cycle count and order/illegal pulses from the sampled lamp code.
    always_comb begin
        state_nxt  = state;
        locked_nxt = locked;
        cnt_nxt    = cycle_count;
        ill        = 1'b0;
        bo         = 1'b0;
        if (!valid) begin
            state_nxt  = ACQUIRE;
            locked_nxt = 1'b0;
            ill        = 1'b1;
        end else if (state == ACQUIRE) begin
            state_nxt = state_t'(code + 2'd1);
        end else if (code == nxt_code) begin
            state_nxt  = state_t'(code + 2'd1);
            locked_nxt = 1'b1;
            cnt_nxt    = (code == 2'd0) ? cycle_count + CNT_W'(1) : cycle_count;
        end else if (code != cur) begin
            state_nxt  = state_t'(code + 2'd1);
            locked_nxt = 1'b0;
            bo         = 1'b1;
        end
    end

`ifdef DWELL_CHECK_EN
    logic [7:0] dwell, dwell_nxt;
    logic       held;

    assign held      = valid && state != ACQUIRE && code == cur;
    assign dwell_nxt = !valid ? 8'd0 : !held ? 8'd1 : (dwell == 8'hff) ? dwell : dwell + 8'd1;
    assign de        = held && dwell == 8'(MAX_DWELL);

    // Saturating count of consecutive samples of the current colour.
    always_ff @(posedge clock) begin
        if (reset) dwell <= 8'd0;
        else if (primed) dwell <= dwell_nxt;
    end
`else
    assign de = 1'b0;
`endif

    // Input sample register, FSM state and all registered outputs; sticky flag lags the pulses by one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            light_q      <= 3'b000;
            primed       <= 1'b0;
            state        <= ACQUIRE;
            color        <= 2'b11;
            locked       <= 1'b0;
            illegal_code <= 1'b0;
            bad_order    <= 1'b0;
            dwell_err    <= 1'b0;
            cycle_count  <= '0;
            err_sticky   <= 1'b0;
        end else begin
            light_q    <= light;
            primed     <= 1'b1;
            err_sticky <= err_sticky | illegal_code | bad_order | dwell_err;
            if (primed) begin
                state        <= state_nxt;
                color        <= valid ? code : 2'b11;
                locked       <= locked_nxt;
                illegal_code <= ill;
                bad_order    <= bo;
                dwell_err    <= de;
                cycle_count  <= cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_lamp_sequence_checker.sv
// tb_lamp_sequence_checker: directed lamp sequences with a queued scoreboard checked by a monitor.
module tb_lamp_sequence_checker;

    localparam logic [2:0] R = 3'b100, G = 3'b010, Y = 3'b001;
    localparam logic [1:0] CR = 2'd0, CG = 2'd1, CY = 2'd2, CX = 2'd3;
`ifdef DWELL_CHECK_EN
    localparam logic DE = 1'b1;
`else
    localparam logic DE = 1'b0;
`endif

    typedef struct {
        int         due;
        int         id;
        logic [8:0] exp;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [0:2] light = 3'b100;
    logic [1:0] color;
    logic       locked, illegal_code, bad_order, dwell_err, err_sticky;
    logic [1:0] cycle_count;
    int         cyc = 0;
    int         passed = 0;
    int         total = 0;
    int         nstep = 0;
    exp_t       q[$];

    lamp_sequence_checker #(.MAX_DWELL(4), .CNT_W(2)) dut (
        .clock(clock), .reset(reset), .light(light), .color(color), .locked(locked),
        .illegal_code(illegal_code), .bad_order(bad_order), .dwell_err(dwell_err),
        .cycle_count(cycle_count), .err_sticky(err_sticky)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // A sample taken at the next edge shows up one edge later; a reset shows up right after its edge
    // and discards the sample that was still in flight.
    task automatic step(input logic r, input logic [2:0] l, input logic [1:0] c, input logic lk,
                        input logic il, input logic b, input logic d, input logic [1:0] cn, input logic st);
        int due;
        @(negedge clock);
        reset = r;
        light = l;
        due = r ? cyc + 1 : cyc + 2;
        if (r && q.size() > 0 && q[$].due == due) void'(q.pop_back());
        q.push_back('{due, nstep, {c, lk, il, b, d, cn, st}});
        nstep++;
    endtask

    always @(negedge clock) begin
        while (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            logic [8:0] act;
            e = q.pop_front();
            act = {color, locked, illegal_code, bad_order, dwell_err, cycle_count, err_sticky};
            total++;
            if (act === e.exp) passed++;
            else $display("FAIL step%0d: got {color,locked,ill,bo,de,cnt,sticky}=%b expected %b", e.id, act, e.exp);
        end
    end

    initial begin
        step(1, R, CX, 0, 0, 0, 0, 0, 0);
        step(1, R, CX, 0, 0, 0, 0, 0, 0);
        step(0, R, CR, 0, 0, 0, 0, 0, 0);
        step(0, G, CG, 1, 0, 0, 0, 0, 0);
        step(0, Y, CY, 1, 0, 0, 0, 0, 0);
        step(0, R, CR, 1, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            step(0, G, CG, 1, 0, 0, 0, 2'(k), 0);
            step(0, Y, CY, 1, 0, 0, 0, 2'(k), 0);
            step(0, R, CR, 1, 0, 0, 0, 2'(k + 1), 0);
        end
        step(0, Y, CY, 0, 0, 1, 0, 1, 0);
        step(0, R, CR, 1, 0, 0, 0, 2, 1);
        step(0, G, CG, 1, 0, 0, 0, 2, 1);
        step(0, 3'b110, CX, 0, 1, 0, 0, 2, 1);
        step(0, Y, CY, 0, 0, 0, 0, 2, 1);
        step(0, Y, CY, 0, 0, 0, 0, 2, 1);
        step(0, R, CR, 1, 0, 0, 0, 3, 1);
        step(0, 3'b000, CX, 0, 1, 0, 0, 3, 1);
        step(0, 3'b111, CX, 0, 1, 0, 0, 3, 1);
        for (int i = 1; i <= 7; i++) step(0, G, CG, 0, 0, 0, (i == 5) ? DE : 1'b0, 3, 1);
        step(0, Y, CY, 1, 0, 0, 0, 3, 1);
        step(0, Y, CY, 1, 0, 0, 0, 3, 1);
        step(1, G, CX, 0, 0, 0, 0, 0, 0);
        step(0, G, CG, 0, 0, 0, 0, 0, 0);
        step(0, Y, CY, 1, 0, 0, 0, 0, 0);
        step(0, R, CR, 1, 0, 0, 0, 1, 0);
        repeat (4) @(negedge clock);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expected responses never checked, required 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
